// File: rtl/ccu_dispatch.sv
// Instruction dispatcher: assembles multi-word ISA instructions and queues them per target engine.
// Optional per-target handshake counters are built when CCU_DISPATCH_PERF_EN is defined.
module ccu_dispatch #(
  parameter int PORT_WIDTH = 128,
  parameter int NUM_TGT    = 5,
  parameter int MAX_WORDS  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [PORT_WIDTH-1:0]                   isa_dat,
  input  logic                                    isa_vld,
  output logic                                    isa_rdy,
  output logic [NUM_TGT-1:0]                      cfg_vld,
  input  logic [NUM_TGT-1:0]                      cfg_rdy,
  output logic [NUM_TGT*MAX_WORDS*PORT_WIDTH-1:0] cfg_info,
`ifdef CCU_DISPATCH_PERF_EN
  output logic [NUM_TGT*32-1:0]                   perf_cnt,
`endif
  output logic                                    err_illegal,
  input  logic                                    err_clr,
  output logic [NUM_TGT-1:0]                      tgt_full
);

  localparam int ENTRY_W = MAX_WORDS * PORT_WIDTH;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, PUSH, DROP} state_t;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t               state;
  logic [7:0]           wordCnt;
  logic [7:0]           numWordsQ;
  logic [ENTRY_W-1:0]   entryQ;

  logic                 wordAcc;
  logic [7:0]           hdrOp;
  logic [7:0]           hdrWords;
  logic                 hdrOpOk;
  logic                 hdrLenOk;
  logic [7:0]           pushOp;
  logic                 pushFlush;
  logic                 pushEn;
  logic [NUM_TGT-1:0]   pushSel;
  logic [NUM_TGT-1:0]   popEn;

  assign wordAcc   = isa_vld & isa_rdy;
  assign hdrOp     = isa_dat[7:0];
  assign hdrWords  = isa_dat[15:8];
  assign hdrOpOk   = {1'b0, hdrOp} < 9'(NUM_TGT);
  assign hdrLenOk  = (hdrWords != 8'd0) && ({1'b0, hdrWords} <= 9'(MAX_WORDS));
  assign pushOp    = entryQ[7:0];
  assign pushFlush = entryQ[16];
  // A flush overrides the full check; otherwise full comes from the registered count only
  assign pushEn    = (state == PUSH) && (pushFlush || ((pushSel & tgt_full) == '0));
  assign popEn     = cfg_vld & cfg_rdy;

  // Stage: header decode / word collection FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wordCnt   <= '0;
      numWordsQ <= '0;
      isa_rdy   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (wordAcc) begin
          if (hdrLenOk) begin
            wordCnt   <= 8'd1;
            numWordsQ <= hdrWords;
            if (hdrOpOk) begin
              if (hdrWords == 8'd1) begin
                state   <= PUSH;
                isa_rdy <= 1'b0;
              end else begin
                state <= COLLECT;
              end
            end else if (hdrWords != 8'd1) begin
              state <= DROP;
            end
          end
        end
        COLLECT: if (wordAcc) begin
          wordCnt <= wordCnt + 8'd1;
          if (wordCnt == numWordsQ - 8'd1) begin
            state   <= PUSH;
            isa_rdy <= 1'b0;
          end
        end
        DROP: if (wordAcc) begin
          wordCnt <= wordCnt + 8'd1;
          if (wordCnt == numWordsQ - 8'd1) state <= IDLE;
        end
        PUSH: if (pushEn) begin
          state   <= IDLE;
          isa_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (err_clr) begin
      err_illegal <= 1'b0;
    end else if ((state == IDLE) && wordAcc && !(hdrOpOk && hdrLenOk)) begin
      err_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && wordAcc && hdrOpOk && hdrLenOk) begin
      entryQ <= ENTRY_W'(isa_dat);
    end else if ((state == COLLECT) && wordAcc) begin
      for (int k = 1; k < MAX_WORDS; k++) begin
        if (wordCnt == 8'(k)) entryQ[k*PORT_WIDTH +: PORT_WIDTH] <= isa_dat;
      end
    end
  end

  // Stage: per-target first-word fall-through FIFOs
  for (genvar t = 0; t < NUM_TGT; t++) begin : gTgt
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic [CNT_W-1:0]   cnt;
    logic               push;
    logic               flush;

    assign pushSel[t] = (pushOp == 8'(t));
    assign push       = pushEn & pushSel[t];
    assign flush      = push & pushFlush;

    always_ff @(posedge clk) begin
      if (push) mem[flush ? '0 : wrPtr] <= entryQ;
    end

    // A flush restarts the FIFO at slot 0 holding only the new entry, swallowing any same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdPtr <= '0;
        wrPtr <= '0;
        cnt   <= '0;
      end else if (flush) begin
        rdPtr <= '0;
        wrPtr <= nextPtr('0);
        cnt   <= CNT_W'(1);
      end else begin
        if (push) wrPtr <= nextPtr(wrPtr);
        if (popEn[t]) rdPtr <= nextPtr(rdPtr);
        if (push && !popEn[t]) cnt <= cnt + 1'b1;
        else if (!push && popEn[t]) cnt <= cnt - 1'b1;
      end
    end

    assign cfg_vld[t]  = (cnt != '0);
    assign tgt_full[t] = (cnt == DEPTH_C);
    assign cfg_info[t*ENTRY_W +: ENTRY_W] = cfg_vld[t] ? mem[rdPtr] : '0;

`ifdef CCU_DISPATCH_PERF_EN
    logic [31:0] perfQ;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perfQ <= '0;
      else if (popEn[t]) perfQ <= satInc(perfQ);
    end
    assign perf_cnt[t*32 +: 32] = perfQ;
`endif
  end

endmodule

// File: tb/tb_ccu_dispatch.sv
// Bench for ccu_dispatch: directed scenarios followed by random instructions against per-target queue model.
module tb_ccu_dispatch;
  localparam int PW = 128;
  localparam int NT = 5;
  localparam int MW = 16;
  localparam int FD = 2;
  localparam int EW = MW * PW;

  typedef logic [EW-1:0] entry_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [PW-1:0]        isa_dat = '0;
  logic                 isa_vld = 1'b0;
  logic                 isa_rdy;
  logic [NT-1:0]        cfg_vld;
  logic [NT-1:0]        cfg_rdy = '0;
  logic [NT*EW-1:0]     cfg_info;
  logic                 err_illegal;
  logic                 err_clr = 1'b0;
  logic [NT-1:0]        tgt_full;

  ccu_dispatch #(.PORT_WIDTH(PW), .NUM_TGT(NT), .MAX_WORDS(MW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .isa_dat(isa_dat), .isa_vld(isa_vld), .isa_rdy(isa_rdy),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_info(cfg_info),
    .err_illegal(err_illegal), .err_clr(err_clr), .tgt_full(tgt_full)
  );

  always #5 clk = ~clk;

  entry_t modelQ [NT][$];
  bit     modelErr = 1'b0;
  int     total = 0;
  int     bad = 0;

  function automatic logic [31:0] fold(input entry_t v);
    logic [31:0] f = '0;
    for (int i = 0; i < EW / 32; i++) f ^= v[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [PW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [PW-1:0] mkHdr(input int op, input int nw, input bit fl);
    logic [PW-1:0] h = rnd128();
    h[7:0]  = 8'(op);
    h[15:8] = 8'(nw);
    h[16]   = fl;
    return h;
  endfunction

  function automatic entry_t slice(input int t);
    return cfg_info[t*EW +: EW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkEntry(input string tag, input entry_t obs, input entry_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed fold=%0h low=%0h expected fold=%0h low=%0h",
             tag, fold(obs), obs[63:0], fold(exp), exp[63:0]);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int t = 0; t < NT; t++) begin
      chk($sformatf("%s_vld%0d", tag, t), 64'(cfg_vld[t]), 64'(modelQ[t].size() != 0));
      chk($sformatf("%s_full%0d", tag, t), 64'(tgt_full[t]), 64'(modelQ[t].size() == FD));
      chkEntry($sformatf("%s_info%0d", tag, t), slice(t),
               (modelQ[t].size() != 0) ? modelQ[t][0] : entry_t'(0));
    end
    chk({tag, "_err"}, 64'(err_illegal), 64'(modelErr));
    chk({tag, "_rdy"}, 64'(isa_rdy), 64'd1);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting clock edge.
  task automatic sendWord(input logic [PW-1:0] d);
    int n = 0;
    isa_dat = d;
    isa_vld = 1'b1;
    while (!isa_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!isa_rdy) chk("rdy_timeout", 64'(isa_rdy), 64'd1);
    @(negedge clk);
    isa_vld = 1'b0;
  endtask

  task automatic sendInstr(input int op, input int nw, input bit fl, output entry_t e);
    logic [PW-1:0] h = mkHdr(op, nw, fl);
    logic [PW-1:0] w;
    int cnt = (nw == 0 || nw > MW) ? 1 : nw;
    e = entry_t'(h);
    sendWord(h);
    for (int k = 1; k < cnt; k++) begin
      w = rnd128();
      e[k*PW +: PW] = w;
      sendWord(w);
    end
  endtask

  function automatic void modelApply(input int op, input int nw, input bit fl, input entry_t e);
    if (nw == 0 || nw > MW || op >= NT) modelErr = 1'b1;
    else begin
      if (fl) modelQ[op].delete();
      modelQ[op].push_back(e);
    end
  endfunction

  task automatic doInstr(input int op, input int nw, input bit fl);
    entry_t e;
    sendInstr(op, nw, fl, e);
    tick();
    modelApply(op, nw, fl, e);
  endtask

  task automatic popTgt(input int t);
    chk($sformatf("pop_vld%0d", t), 64'(cfg_vld[t]), 64'(modelQ[t].size() != 0));
    if (modelQ[t].size() != 0) begin
      cfg_rdy[t] = 1'b1;
      tick();
      cfg_rdy[t] = 1'b0;
      void'(modelQ[t].pop_front());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] h;
    logic [PW-1:0] wa;
    logic [PW-1:0] wb;
    entry_t e;

    repeat (3) tick();
    checkAll("reset");
    rst_n = 1'b1;
    tick();

    // Three-word instruction to target 2, consumer not ready
    h = mkHdr(2, 3, 1'b0);
    wa = rnd128();
    wb = rnd128();
    sendWord(h);
    sendWord(wa);
    sendWord(wb);
    chk("lat3_vld_early", 64'(cfg_vld[2]), 64'd0);
    tick();
    e = '0;
    e[0 +: PW] = h;
    e[PW +: PW] = wa;
    e[2*PW +: PW] = wb;
    chk("lat3_vld", 64'(cfg_vld[2]), 64'd1);
    chkEntry("lat3_info", slice(2), e);
    modelQ[2].push_back(e);
    repeat (2) tick();
    checkAll("hold3");
    popTgt(2);
    checkAll("pop3");

    // Single-word latency
    h = mkHdr(3, 1, 1'b0);
    sendWord(h);
    chk("lat1_vld_early", 64'(cfg_vld[3]), 64'd0);
    tick();
    chk("lat1_vld", 64'(cfg_vld[3]), 64'd1);
    modelQ[3].push_back(entry_t'(h));
    popTgt(3);

    // Fill target 0 and stall the third push
    doInstr(0, 1, 1'b0);
    doInstr(0, 1, 1'b0);
    checkAll("full0");
    h = mkHdr(0, 1, 1'b0);
    sendWord(h);
    tick();
    chk("stall_rdy", 64'(isa_rdy), 64'd0);
    chk("stall_full", 64'(tgt_full[0]), 64'd1);
    chkEntry("stall_head", slice(0), modelQ[0][0]);
    cfg_rdy[0] = 1'b1;
    tick();
    cfg_rdy[0] = 1'b0;
    void'(modelQ[0].pop_front());
    chk("stall_pop_rdy", 64'(isa_rdy), 64'd0);
    chk("stall_pop_full", 64'(tgt_full[0]), 64'd0);
    chkEntry("stall_pop_head", slice(0), modelQ[0][0]);
    tick();
    modelQ[0].push_back(entry_t'(h));
    checkAll("unstall");
    popTgt(0);
    popTgt(0);

    // Flush on a target holding two entries
    doInstr(1, 2, 1'b0);
    doInstr(1, 1, 1'b0);
    doInstr(1, 3, 1'b1);
    checkAll("flush");
    // Flush coinciding with a consumer handshake
    doInstr(1, 1, 1'b0);
    h = mkHdr(1, 1, 1'b1);
    sendWord(h);
    cfg_rdy[1] = 1'b1;
    tick();
    cfg_rdy[1] = 1'b0;
    modelQ[1].delete();
    modelQ[1].push_back(entry_t'(h));
    checkAll("flush_pop");
    popTgt(1);

    // Illegal opcode with body, then legal instruction decoded correctly
    doInstr(7, 4, 1'b0);
    checkAll("badop");
    doInstr(4, 2, 1'b0);
    checkAll("after_badop");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    modelErr = 1'b0;
    checkAll("errclr");
    // err_clr wins over a simultaneous illegal header
    err_clr = 1'b1;
    sendWord(mkHdr(9, 1, 1'b0));
    err_clr = 1'b0;
    chk("errclr_prio", 64'(err_illegal), 64'd0);

    // Zero and oversize word counts consume only the header
    doInstr(1, 0, 1'b0);
    doInstr(2, 1, 1'b0);
    checkAll("nw0");
    doInstr(3, MW + 1, 1'b0);
    doInstr(3, 1, 1'b0);
    checkAll("nw17");

    // Asynchronous reset in the middle of a collection
    h = mkHdr(0, 5, 1'b0);
    sendWord(h);
    sendWord(rnd128());
    #2;
    rst_n = 1'b0;
    #1;
    for (int t = 0; t < NT; t++) modelQ[t].delete();
    modelErr = 1'b0;
    checkAll("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    doInstr(0, 3, 1'b0);
    checkAll("postrst");
    popTgt(0);

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      int act = $urandom_range(0, 5);
      if (act <= 2) begin
        int op = $urandom_range(0, 6);
        int nw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) * $urandom_range(17, 20)
                                             : $urandom_range(1, MW);
        bit fl = ($urandom_range(0, 4) == 0);
        if (op < NT && nw >= 1 && nw <= MW && !fl && modelQ[op].size() == FD) popTgt(op);
        doInstr(op, nw, fl);
      end else if (act <= 4) begin
        popTgt($urandom_range(0, NT - 1));
      end else begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        modelErr = 1'b0;
      end
      checkAll($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
